// File: rtl/placement_if.sv
// -----------------------------------------------------------------------------
// placement_if
// Bundles the signals between the game controller and the ship-placement
// stage. Clock and reset stay plain ports on the modules.
//
//   placement_State      controller -> stage  high while in ship-placement state
//   ships_decided        controller -> stage  ship amount has been confirmed
//   player_amount_ships  controller -> stage  ships to place (3 bits)
//   btn_up/down/left/right/place
//                        controller -> stage  debounced active-high levels
//   cursor_x, cursor_y   stage -> controller  cursor column/row, 0..BOARD_N-1
//   board                stage -> controller  occupancy map, bit = y*BOARD_N + x
//   ships_placed         stage -> controller  ships placed so far
//   placement_done       stage -> controller  high while placement is complete
//   place_error          stage -> controller  one-cycle pulse on rejected place
//
// master: the controller side (drives the requests and buttons).
// slave:  the placement stage (drives the cursor, board and status).
// -----------------------------------------------------------------------------
interface placement_if #(
  parameter int BOARD_N = 5
);
  logic                         placement_State;
  logic                         ships_decided;
  logic [2:0]                   player_amount_ships;
  logic                         btn_up;
  logic                         btn_down;
  logic                         btn_left;
  logic                         btn_right;
  logic                         btn_place;
  logic [2:0]                   cursor_x;
  logic [2:0]                   cursor_y;
  logic [BOARD_N*BOARD_N-1:0]   board;
  logic [2:0]                   ships_placed;
  logic                         placement_done;
  logic                         place_error;

  modport master (
    output placement_State, ships_decided, player_amount_ships,
    output btn_up, btn_down, btn_left, btn_right, btn_place,
    input  cursor_x, cursor_y, board, ships_placed, placement_done, place_error
  );

  modport slave (
    input  placement_State, ships_decided, player_amount_ships,
    input  btn_up, btn_down, btn_left, btn_right, btn_place,
    output cursor_x, cursor_y, board, ships_placed, placement_done, place_error
  );
endinterface

// File: rtl/placement_state.sv
// -----------------------------------------------------------------------------
// placement_state
// Ship-placement stage of the board game. While the controller holds
// placement_State, the player moves a wrapping cursor with the direction
// buttons and drops ships with btn_place until the requested number (capped
// at BOARD_N) has been placed. The finished board is held for the attack
// stage until the next placement round begins.
//
// Ports
//   clk    game clock; every register updates on the falling edge
//   rst    asynchronous, active-low reset
//   bus    placement_if.slave (requests/buttons in, cursor/board/status out)
// -----------------------------------------------------------------------------
module placement_state #(
  parameter int BOARD_N = 5
) (
  input  logic         clk,
  input  logic         rst,
  placement_if.slave   bus
);

  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [2:0] COORD_MAX  = 3'(BOARD_N - 1);
  localparam logic [2:0] TARGET_MAX = 3'(BOARD_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLACE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Button vector layout: {up, down, left, right, place}
  localparam int B_UP    = 4;
  localparam int B_DOWN  = 3;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 1;
  localparam int B_PLACE = 0;

  state_t           state_q, state_d;
  logic [2:0]       cx_q, cx_d;
  logic [2:0]       cy_q, cy_d;
  logic [2:0]       ships_q, ships_d;
  logic [2:0]       target_q, target_d;
  logic [CELLS-1:0] board_q, board_d;
  logic             err_q, err_d;

  logic [4:0]       btn_now;
  logic [4:0]       btn_prev_q;
  logic [4:0]       btn_edge;
  logic [IDX_W-1:0] cell_idx;

  assign btn_now  = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right, bus.btn_place};
  // A held button produces one action: only the rising level counts.
  assign btn_edge = btn_now & ~btn_prev_q;

  // Cell under the cursor before any move in this cycle is applied.
  assign cell_idx = IDX_W'(cy_q) * IDX_W'(BOARD_N) + IDX_W'(cx_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      ships_q    <= '0;
      target_q   <= '0;
      board_q    <= '0;
      err_q      <= 1'b0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      ships_q    <= ships_d;
      target_q   <= target_d;
      board_q    <= board_d;
      err_q      <= err_d;
      btn_prev_q <= btn_now;
    end
  end

  // NOTE: every variable gets a default before the case statement so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    ships_d  = ships_q;
    target_d = target_q;
    board_d  = board_q;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.placement_State && bus.ships_decided && (bus.player_amount_ships != 3'd0)) begin
          state_d  = PLACE;
          target_d = (bus.player_amount_ships > TARGET_MAX) ? TARGET_MAX : bus.player_amount_ships;
          board_d  = '0;
          ships_d  = '0;
          cx_d     = '0;
          cy_d     = '0;
        end
      end

      PLACE: begin
        if (!bus.placement_State) begin
          // Controller left placement early: the round is abandoned.
          state_d = IDLE;
          board_d = '0;
          ships_d = '0;
          cx_d    = '0;
          cy_d    = '0;
        end else begin
          if (btn_edge[B_PLACE]) begin
            if (board_q[cell_idx]) begin
              err_d = 1'b1;
            end else begin
              board_d[cell_idx] = 1'b1;
              ships_d           = 3'(ships_q + 3'd1);
              if (3'(ships_q + 3'd1) == target_q) begin
                state_d = DONE;
              end
            end
          end

          // One move per cycle, priority up > down > left > right.
          if (btn_edge[B_UP]) begin
            cy_d = (cy_q == 3'd0) ? COORD_MAX : 3'(cy_q - 3'd1);
          end else if (btn_edge[B_DOWN]) begin
            cy_d = (cy_q == COORD_MAX) ? 3'd0 : 3'(cy_q + 3'd1);
          end else if (btn_edge[B_LEFT]) begin
            cx_d = (cx_q == 3'd0) ? COORD_MAX : 3'(cx_q - 3'd1);
          end else if (btn_edge[B_RIGHT]) begin
            cx_d = (cx_q == COORD_MAX) ? 3'd0 : 3'(cx_q + 3'd1);
          end
        end
      end

      DONE: begin
        // Board and count stay visible to the attack stage.
        if (!bus.placement_State) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.cursor_x       = cx_q;
  assign bus.cursor_y       = cy_q;
  assign bus.board          = board_q;
  assign bus.ships_placed   = ships_q;
  assign bus.placement_done = (state_q == DONE);
  assign bus.place_error    = err_q;

endmodule

// File: doc/placement_state.md
PLACEMENT_STATE -- requirements
Module: placement_state

Interface
REQ-001 Parameter: BOARD_N, 5, board edge length in cells; fixed at 5 for this game, giving 25 cells and 3-bit coordinates.
REQ-002 clk  input  1  game clock; all registers update on the falling edge, consistent with the game controller stages.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 placement_State  input  1  high while the game controller is in the ship-placement state.
REQ-005 ships_decided  input  1  ship amount confirmed by the preceding decision stage.
REQ-006 player_amount_ships  input  3  number of ships the player must place.
REQ-007 btn_up, btn_down, btn_left, btn_right, btn_place  input  1 each  debounced, synchronous, active-high button levels.
REQ-008 cursor_x, cursor_y  output  3 each  cursor column and row, range 0..4.
REQ-009 board  output  25  occupancy map; bit index = cursor_y*5 + cursor_x; 1 = ship.
REQ-010 ships_placed  output  3  number of ships placed so far.
REQ-011 placement_done  output  1  level, high in the DONE state.
REQ-012 place_error  output  1  one-cycle pulse on a rejected placement.

Function
REQ-013 States SHALL be IDLE, PLACE and DONE, encoded as 2 bits; no other state shall be reachable.
REQ-014 Each button action SHALL fire only on a 0->1 edge, detected against the previous-cycle registered level; a held button yields exactly one action.
REQ-015 IDLE->PLACE occurs when placement_State=1 and ships_decided=1 and player_amount_ships!=0.
  - Target is latched as min(player_amount_ships, 5).
  - board is cleared to 0, ships_placed to 0, and the cursor to (0,0).
REQ-016 In IDLE with player_amount_ships=0, the block SHALL remain in IDLE.
REQ-017 In PLACE, a direction edge moves the cursor by one cell with wrap-around: x=4 +right->0, x=0 +left->4; y=0 +up->4, y=4 +down->0.
REQ-018 If several direction edges occur in the same cycle, only one SHALL apply, by priority up>down>left>right.
REQ-019 In PLACE, a btn_place edge on a free cell SHALL set that board bit and increment ships_placed, both visible in the next cycle.
REQ-020 In PLACE, a btn_place edge on an occupied cell SHALL leave board and ships_placed unchanged and pulse place_error for exactly one cycle.
REQ-021 If a place edge and a move edge occur in the same cycle, the placement SHALL use the pre-move cursor and the move SHALL also apply.
REQ-022 When ships_placed reaches the target, the FSM SHALL enter DONE in the same update.
  - From that point placement_done=1.
  - Further button edges are ignored.
REQ-023 DONE->IDLE occurs when placement_State=0; board and ships_placed are retained for the attack stage until the next IDLE->PLACE entry.
REQ-024 If placement_State drops while in PLACE, the block SHALL abort to IDLE and clear board, ships_placed and the cursor to 0.
REQ-025 ships_placed SHALL never exceed the target and never exceed 5; there is no overflow path.
REQ-026 place_error SHALL be 0 in every state other than PLACE.

Reset
REQ-027 With rst=0, the block SHALL immediately, without waiting for clk, set:
  - state=IDLE;
  - cursor_x=0 and cursor_y=0;
  - board=0 and ships_placed=0;
  - placement_done=0 and place_error=0;
  - all button-history registers to 0.
REQ-028 Reset asserted mid-PLACE SHALL discard all progress; after release, the block SHALL wait in IDLE for a fresh entry condition.

Verification
REQ-029 Enter with amount=3; press place at (0,0), right, place, down, place -> board bits 0, 1 and 6 set, ships_placed=3, placement_done=1.
REQ-030 Enter with amount=2; place twice at the same cell -> second press gives place_error pulse of 1 cycle, ships_placed stays 1, board=0x0000001.
REQ-031 Cursor at (0,0); press left, then up -> cursor (4,0), then (4,4); hold btn_right 10 cycles -> cursor_x advances exactly once, to 0.
REQ-032 amount=7 -> target clamps to 5, DONE after the 5th placement; amount=0 with ships_decided=1 -> stays in IDLE, board=0.
REQ-033 Drop placement_State after 1 placement -> IDLE, board=0, ships_placed=0; re-enter -> fresh board.
REQ-034 Assert rst mid-PLACE between clock edges -> all outputs are 0 before the next clk edge; btn_up and btn_place edges in the same cycle at (2,2) -> bit 12 set and cursor moves to (2,1).
